// File: rtl/branch_ctrl.sv
// Branch decode/resolution between fetch and ID: combinational same-cycle controls, NZCV register, one-cycle squash after a taken branch.
// No backpressure; BL link support is enabled by defining BR_LINK_EN.
module branch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic        rt_zero,
   input  logic        flag_wr,
   input  logic        n_in,
   input  logic        z_in,
   input  logic        c_in,
   input  logic        v_in,
   output logic        BrTaken,
   output logic        UncondBr,
   output logic [18:0] CondAddr19,
   output logic [25:0] BrAddr26,
   output logic        inst_valid,
   output logic [3:0]  flags,
   output logic        link_we
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SQUASH = 2'd2} state_t;

   state_t     state, state_nxt;
   logic [3:0] flags_new;
   logic [3:0] flags_eff;
   logic       n, z, c, v;
   logic       cond_ok;
   logic       is_b, is_cbz, is_cbnz, is_bcond;
`ifdef BR_LINK_EN
   logic       is_bl;
   assign is_bl = (instruction[31:26] == 6'b100101);
`endif

   assign flags_new = {n_in, z_in, c_in, v_in};
   // A flag write in the same cycle bypasses the register for B.cond
   assign flags_eff = flag_wr ? flags_new : flags;
   assign {n, z, c, v} = flags_eff;

   assign is_b     = (instruction[31:26] == 6'b000101);
   assign is_cbz   = (instruction[31:24] == 8'b10110100);
   assign is_cbnz  = (instruction[31:24] == 8'b10110101);
   assign is_bcond = (instruction[31:24] == 8'b01010100);

   always_comb begin
      cond_ok = 1'b0;
      case (instruction[3:0])
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = !z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = !c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = !n;
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = !z && (n == v);
         4'b1101: cond_ok = z || (n != v);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         flags <= 4'b0000;
      else if (flag_wr) flags <= flags_new;
   end

   always_comb begin
      state_nxt  = state;
      BrTaken    = 1'b0;
      UncondBr   = 1'b0;
      CondAddr19 = 19'd0;
      BrAddr26   = 26'd0;
      inst_valid = 1'b0;
      link_we    = 1'b0;
      case (state)
         IDLE:   state_nxt = RUN;
         SQUASH: state_nxt = RUN;
         RUN: begin
            inst_valid = 1'b1;
            CondAddr19 = instruction[23:5];
            BrAddr26   = instruction[25:0];
            if (is_b) begin
               BrTaken  = 1'b1;
               UncondBr = 1'b1;
            end
`ifdef BR_LINK_EN
            else if (is_bl) begin
               BrTaken  = 1'b1;
               UncondBr = 1'b1;
               link_we  = 1'b1;
            end
`endif
            else if (is_cbz)   BrTaken = rt_zero;
            else if (is_cbnz)  BrTaken = !rt_zero;
            else if (is_bcond) BrTaken = cond_ok;
            // The PC+4 instruction arriving next cycle is on the wrong path
            if (BrTaken) state_nxt = SQUASH;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
